// File: rtl/csr_counter_bank.sv
// ---------------------------------------------------------------------------
// csr_counter_bank
//
// Machine-mode performance counter bank: mcycle, minstret, HPM_NUM
// mhpmcounterN/mhpmeventN pairs (N = 3..3+HPM_NUM-1), mcountinhibit, and the
// read-only user shadows cycle/instret/hpmcounterN.
//
// Optional feature macro: CSR_COUNTER_OVF_IRQ_EN
//   defined   -> sticky per-counter overflow flags, ovf_irq = registered OR
//   undefined -> no flags, ovf_irq tied to 0
//
// Ports
//   CLK             in   single clock, rising edge
//   RST             in   synchronous active-high reset
//   csr_addr        in   12-bit CSR address
//   csr_wen         in   write strobe for csr_addr
//   csr_data_write  in   XLEN-bit write data
//   csr_data_read   out  XLEN-bit combinational read data (0 when unmapped)
//   csr_hit         out  csr_addr maps to a register in this block
//   retire_cnt      in   instructions retired this cycle (3 counts as 2)
//   hpm_event       in   EVT_NUM per-cycle event pulses
//   ovf_irq         out  counter overflow interrupt request
// ---------------------------------------------------------------------------
module csr_counter_bank #(
   parameter int XLEN    = 64,
   parameter int HPM_NUM = 4,
   parameter int EVT_NUM = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [11:0]        csr_addr,
   input  logic               csr_wen,
   input  logic [XLEN-1:0]    csr_data_write,
   output logic [XLEN-1:0]    csr_data_read,
   output logic               csr_hit,
   input  logic [1:0]         retire_cnt,
   input  logic [EVT_NUM-1:0] hpm_event,
   output logic               ovf_irq
);

   // Arrays keep at least one entry so HPM_NUM = 0 still elaborates.
   localparam int HPM_SZ = (HPM_NUM > 0) ? HPM_NUM : 1;

   // Writable mcountinhibit bits: CY (0), IR (2) and one bit per HPM counter.
   function automatic logic [31:0] inhibit_mask(input int num);
      logic [31:0] m;
      m = 32'h0000_0005;
      for (int i = 0; i < num; i++) begin
         m[3+i] = 1'b1;
      end
      return m;
   endfunction

   // Selector k (1..EVT_NUM) picks hpm_event[k-1]; 0 and out-of-range never fire.
   function automatic logic event_fire(input logic [7:0] sel,
                                       input logic [EVT_NUM-1:0] evt);
      logic fire;
      fire = 1'b0;
      for (int k = 0; k < EVT_NUM; k++) begin
         fire = fire | ((sel == 8'(k + 1)) & evt[k]);
      end
      return fire;
   endfunction

   localparam logic [31:0] INH_MASK = inhibit_mask(HPM_NUM);

   logic [XLEN-1:0]   mcycle_r;
   logic [XLEN-1:0]   minstret_r;
   logic [XLEN-1:0]   hpm_cnt_r [HPM_SZ];
   logic [7:0]        hpm_evt_r [HPM_SZ];
   logic [31:0]       inhibit_r;

   logic              wr_cycle_s;
   logic              wr_instret_s;
   logic              wr_inhibit_s;
   logic [HPM_SZ-1:0] wr_hpm_cnt_s;
   logic [HPM_SZ-1:0] wr_hpm_evt_s;
   logic [HPM_SZ-1:0] rd_hpm_cnt_s;
   logic [HPM_SZ-1:0] rd_hpm_evt_s;

   logic              cyc_inc_s;
   logic              ret_en_s;
   logic [1:0]        ret_inc_s;
   logic [XLEN-1:0]   ret_sum_s;
   logic [XLEN-1:0]   mcycle_nx_s;
   logic [XLEN-1:0]   minstret_nx_s;
   logic [HPM_SZ-1:0] hpm_inc_s;

   logic [XLEN-1:0]   rd_data_s;
   logic              rd_hit_s;

   // Address decode for writes and for the parameterised HPM ranges.
   always_comb begin
      wr_cycle_s   = csr_wen & (csr_addr == 12'hB00);
      wr_instret_s = csr_wen & (csr_addr == 12'hB02);
      wr_inhibit_s = csr_wen & (csr_addr == 12'h320);
      wr_hpm_cnt_s = {HPM_SZ{1'b0}};
      wr_hpm_evt_s = {HPM_SZ{1'b0}};
      rd_hpm_cnt_s = {HPM_SZ{1'b0}};
      rd_hpm_evt_s = {HPM_SZ{1'b0}};
      for (int i = 0; i < HPM_NUM; i++) begin
         rd_hpm_cnt_s[i] = (csr_addr == (12'hB03 + 12'(i))) |
                           (csr_addr == (12'hC03 + 12'(i)));
         rd_hpm_evt_s[i] = (csr_addr == (12'h323 + 12'(i)));
         wr_hpm_cnt_s[i] = csr_wen & (csr_addr == (12'hB03 + 12'(i)));
         wr_hpm_evt_s[i] = csr_wen & rd_hpm_evt_s[i];
      end
   end

   // Increment enables and next values; a write to a counter suppresses its
   // increment for that cycle.
   always_comb begin
      ret_inc_s = (retire_cnt == 2'd3) ? 2'd2 : retire_cnt;
      cyc_inc_s = ~wr_cycle_s & ~inhibit_r[0];
      ret_en_s  = ~wr_instret_s & ~inhibit_r[2];
      ret_sum_s = minstret_r + XLEN'(ret_inc_s);
      hpm_inc_s = {HPM_SZ{1'b0}};
      for (int i = 0; i < HPM_NUM; i++) begin
         hpm_inc_s[i] = ~wr_hpm_cnt_s[i] & ~inhibit_r[3+i] &
                        event_fire(hpm_evt_r[i], hpm_event);
      end

      if (wr_cycle_s) begin
         mcycle_nx_s = csr_data_write;
      end else if (cyc_inc_s) begin
         mcycle_nx_s = mcycle_r + XLEN'(1'b1);
      end else begin
         mcycle_nx_s = mcycle_r;
      end

      if (wr_instret_s) begin
         minstret_nx_s = csr_data_write;
      end else if (ret_en_s) begin
         minstret_nx_s = ret_sum_s;
      end else begin
         minstret_nx_s = minstret_r;
      end
   end

   // Counter, event-selector and inhibit state; reset wins over everything.
   always_ff @(posedge CLK) begin
      if (RST) begin
         mcycle_r   <= {XLEN{1'b0}};
         minstret_r <= {XLEN{1'b0}};
         inhibit_r  <= 32'h0000_0000;
         for (int i = 0; i < HPM_SZ; i++) begin
            hpm_cnt_r[i] <= {XLEN{1'b0}};
            hpm_evt_r[i] <= 8'h00;
         end
      end else begin
         mcycle_r   <= mcycle_nx_s;
         minstret_r <= minstret_nx_s;
         if (wr_inhibit_s) begin
            inhibit_r <= csr_data_write[31:0] & INH_MASK;
         end else begin
            inhibit_r <= inhibit_r;
         end
         for (int i = 0; i < HPM_NUM; i++) begin
            if (wr_hpm_cnt_s[i]) begin
               hpm_cnt_r[i] <= csr_data_write;
            end else if (hpm_inc_s[i]) begin
               hpm_cnt_r[i] <= hpm_cnt_r[i] + XLEN'(1'b1);
            end else begin
               hpm_cnt_r[i] <= hpm_cnt_r[i];
            end
            if (wr_hpm_evt_s[i]) begin
               hpm_evt_r[i] <= csr_data_write[7:0];
            end else begin
               hpm_evt_r[i] <= hpm_evt_r[i];
            end
         end
      end
   end

   // Read mux: fixed addresses first, then the parameterised HPM ranges.
   always_comb begin
      rd_data_s = {XLEN{1'b0}};
      rd_hit_s  = 1'b0;
      case (csr_addr)
         12'hB00, 12'hC00: begin
            rd_data_s = mcycle_r;
            rd_hit_s  = 1'b1;
         end
         12'hB02, 12'hC02: begin
            rd_data_s = minstret_r;
            rd_hit_s  = 1'b1;
         end
         12'h320: begin
            rd_data_s = XLEN'(inhibit_r);
            rd_hit_s  = 1'b1;
         end
         default: begin
            for (int i = 0; i < HPM_NUM; i++) begin
               rd_data_s = rd_data_s |
                           (rd_hpm_cnt_s[i] ? hpm_cnt_r[i] : {XLEN{1'b0}}) |
                           (rd_hpm_evt_s[i] ? XLEN'(hpm_evt_r[i]) : {XLEN{1'b0}});
            end
            rd_hit_s = (|rd_hpm_cnt_s) | (|rd_hpm_evt_s);
         end
      endcase
   end

   assign csr_data_read = rd_data_s;
   assign csr_hit       = rd_hit_s;

`ifdef CSR_COUNTER_OVF_IRQ_EN
   // Flag index: 0 = mcycle, 1 = minstret, 2+i = mhpmcounter(3+i).
   localparam int CNT_NUM = 2 + HPM_NUM;

   logic [CNT_NUM-1:0] ovf_flag_r;
   logic [CNT_NUM-1:0] ovf_flag_nx_s;
   logic [CNT_NUM-1:0] ovf_set_s;
   logic [CNT_NUM-1:0] ovf_clr_s;
   logic               ovf_irq_r;

   // Wrap detection by increment only; a write clears the flag and, since it
   // suppresses the increment, can never set it in the same cycle.
   always_comb begin
      ovf_set_s    = {CNT_NUM{1'b0}};
      ovf_clr_s    = {CNT_NUM{1'b0}};
      ovf_set_s[0] = cyc_inc_s & (&mcycle_r);
      // minstret adds up to 2, so a wrap shows as the sum dropping below the old value
      ovf_set_s[1] = ret_en_s & (ret_sum_s < minstret_r);
      ovf_clr_s[0] = wr_cycle_s;
      ovf_clr_s[1] = wr_instret_s;
      for (int i = 0; i < HPM_NUM; i++) begin
         ovf_set_s[2+i] = hpm_inc_s[i] & (&hpm_cnt_r[i]);
         ovf_clr_s[2+i] = wr_hpm_cnt_s[i];
      end
      ovf_flag_nx_s = (ovf_flag_r & ~ovf_clr_s) | ovf_set_s;
   end

   // Sticky flags and the registered interrupt, which tracks the flags' new value.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ovf_flag_r <= {CNT_NUM{1'b0}};
         ovf_irq_r  <= 1'b0;
      end else begin
         ovf_flag_r <= ovf_flag_nx_s;
         ovf_irq_r  <= |ovf_flag_nx_s;
      end
   end

   assign ovf_irq = ovf_irq_r;
`else
   assign ovf_irq = 1'b0;
`endif

endmodule

// File: tb/tb_csr_counter_bank.sv
`timescale 1ns/1ps
module tb_csr_counter_bank;
   localparam int XLEN    = 64;
   localparam int HPM_NUM = 4;
   localparam int EVT_NUM = 8;
`ifdef CSR_COUNTER_OVF_IRQ_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   logic               CLK = 1'b0;
   logic               RST;
   logic [11:0]        csr_addr;
   logic               csr_wen;
   logic [XLEN-1:0]    csr_data_write;
   logic [XLEN-1:0]    csr_data_read;
   logic               csr_hit;
   logic [1:0]         retire_cnt;
   logic [EVT_NUM-1:0] hpm_event;
   logic               ovf_irq;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [11:0]     addr;
      logic [XLEN-1:0] data;
      logic            hit;
   } rd_vec_t;

   rd_vec_t         tbl [17];
   logic [XLEN-1:0] all_ones;

   csr_counter_bank #(.XLEN(XLEN), .HPM_NUM(HPM_NUM), .EVT_NUM(EVT_NUM)) dut (
      .CLK            (CLK),
      .RST            (RST),
      .csr_addr       (csr_addr),
      .csr_wen        (csr_wen),
      .csr_data_write (csr_data_write),
      .csr_data_read  (csr_data_read),
      .csr_hit        (csr_hit),
      .retire_cnt     (retire_cnt),
      .hpm_event      (hpm_event),
      .ovf_irq        (ovf_irq)
   );

   always #50 CLK = ~CLK;

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic rd(input string name, input logic [11:0] a,
                     input logic [XLEN-1:0] exp_d, input logic exp_h);
      csr_addr = a;
      #1;
      chk({name, " data"}, csr_data_read, exp_d);
      chk({name, " hit"}, XLEN'(csr_hit), XLEN'(exp_h));
   endtask

   task automatic wr(input logic [11:0] a, input logic [XLEN-1:0] d);
      csr_addr       = a;
      csr_data_write = d;
      csr_wen        = 1'b1;
      tick();
      csr_wen        = 1'b0;
   endtask

   task automatic chk_ovf(input string name, input logic exp);
      chk(name, XLEN'(ovf_irq), XLEN'(exp));
   endtask

   initial begin
      all_ones = {XLEN{1'b1}};
      tbl[0]  = '{12'hB00, 64'd10, 1'b1};
      tbl[1]  = '{12'hC00, 64'd10, 1'b1};
      tbl[2]  = '{12'hB02, 64'd0,  1'b1};
      tbl[3]  = '{12'hC02, 64'd0,  1'b1};
      tbl[4]  = '{12'hB03, 64'd0,  1'b1};
      tbl[5]  = '{12'hB06, 64'd0,  1'b1};
      tbl[6]  = '{12'hC06, 64'd0,  1'b1};
      tbl[7]  = '{12'h320, 64'd0,  1'b1};
      tbl[8]  = '{12'h323, 64'd0,  1'b1};
      tbl[9]  = '{12'h326, 64'd0,  1'b1};
      tbl[10] = '{12'hB01, 64'd0,  1'b0};
      tbl[11] = '{12'hC01, 64'd0,  1'b0};
      tbl[12] = '{12'hB03 + 12'(HPM_NUM), 64'd0, 1'b0};
      tbl[13] = '{12'hC03 + 12'(HPM_NUM), 64'd0, 1'b0};
      tbl[14] = '{12'h321, 64'd0,  1'b0};
      tbl[15] = '{12'h323 + 12'(HPM_NUM), 64'd0, 1'b0};
      tbl[16] = '{12'h7FF, 64'd0,  1'b0};

      RST = 1'b1; csr_addr = 12'h000; csr_wen = 1'b0;
      csr_data_write = {XLEN{1'b0}}; retire_cnt = 2'd0; hpm_event = {EVT_NUM{1'b0}};

      // reset for 3 cycles
      repeat (3) tick();
      RST = 1'b0;
      rd("rst mcycle", 12'hB00, 64'd0, 1'b1);
      rd("rst minstret", 12'hB02, 64'd0, 1'b1);
      chk_ovf("rst ovf_irq", 1'b0);
      tick();
      rd("mcycle after release", 12'hB00, 64'd1, 1'b1);
      repeat (9) tick();

      // idle state readback, including shadows and unmapped addresses
      for (int i = 0; i < 17; i++) begin
         rd($sformatf("tbl[%0d]", i), tbl[i].addr, tbl[i].data, tbl[i].hit);
      end
      chk_ovf("idle ovf_irq", 1'b0);

      // retire counting with saturation of 3 to 2
      retire_cnt = 2'd2;
      repeat (4) tick();
      retire_cnt = 2'd3;
      tick();
      retire_cnt = 2'd0;
      rd("minstret retire", 12'hB02, 64'd10, 1'b1);
      rd("instret shadow", 12'hC02, 64'd10, 1'b1);
      rd("cycle shadow", 12'hC00, 64'd15, 1'b1);

      // write minstret while retiring: old value same cycle, written value after
      csr_addr = 12'hB02; csr_data_write = 64'h1234; csr_wen = 1'b1; retire_cnt = 2'd2;
      #1;
      chk("minstret same-cycle read", csr_data_read, 64'd10);
      tick();
      csr_wen = 1'b0; retire_cnt = 2'd0;
      rd("minstret write wins", 12'hB02, 64'h1234, 1'b1);

      // minstret wrap by 2 from all-ones
      wr(12'hB02, all_ones);
      retire_cnt = 2'd2;
      tick();
      retire_cnt = 2'd0;
      rd("minstret wrap", 12'hB02, 64'd1, 1'b1);
      chk_ovf("minstret wrap ovf", OVF_EN);
      wr(12'hB02, 64'd50);
      chk_ovf("minstret write clears ovf", 1'b0);

      // mcountinhibit freezes cycle and instret, taking effect the next cycle
      wr(12'hB00, 64'd100);
      wr(12'h320, 64'h5);
      retire_cnt = 2'd2;
      repeat (6) tick();
      rd("inhibited mcycle", 12'hB00, 64'd101, 1'b1);
      rd("inhibited minstret", 12'hB02, 64'd50, 1'b1);
      rd("inhibit readback", 12'h320, 64'h5, 1'b1);
      wr(12'h320, 64'h0);
      rd("mcycle at uninhibit", 12'hB00, 64'd101, 1'b1);
      tick();
      retire_cnt = 2'd0;
      rd("mcycle resumed", 12'hB00, 64'd102, 1'b1);
      rd("minstret resumed", 12'hB02, 64'd52, 1'b1);
      wr(12'h320, all_ones);
      rd("inhibit mask", 12'h320, 64'h7D, 1'b1);
      tick();
      wr(12'h320, 64'h0);
      tick();
      rd("mcycle after mask test", 12'hB00, 64'd104, 1'b1);

      // event selection
      wr(12'h323, 64'd2);
      wr(12'h324, 64'd8);
      hpm_event = 8'h02;
      repeat (5) tick();
      hpm_event = 8'h01;
      repeat (3) tick();
      hpm_event = 8'h00;
      rd("hpm3 event2", 12'hB03, 64'd5, 1'b1);
      rd("hpmcounter3 shadow", 12'hC03, 64'd5, 1'b1);
      rd("hpm4 idle", 12'hB04, 64'd0, 1'b1);
      rd("mhpmevent3", 12'h323, 64'd2, 1'b1);
      rd("mhpmevent4", 12'h324, 64'd8, 1'b1);

      // write to hpm3 while its event fires
      csr_addr = 12'hB03; csr_data_write = 64'd1000; csr_wen = 1'b1; hpm_event = 8'h02;
      tick();
      csr_wen = 1'b0;
      rd("hpm3 write wins", 12'hB03, 64'd1000, 1'b1);
      tick();
      hpm_event = 8'h00;
      rd("hpm3 counts after write", 12'hB03, 64'd1001, 1'b1);

      // selector 200 (> EVT_NUM) and 0 never count; selector 8 uses bit 7
      wr(12'h323, 64'hFFFF_FFFF_FFFF_FFC8);
      rd("mhpmevent3 8-bit", 12'h323, 64'hC8, 1'b1);
      hpm_event = 8'hFF;
      repeat (3) tick();
      hpm_event = 8'h00;
      rd("hpm3 sel200", 12'hB03, 64'd1001, 1'b1);
      rd("hpm4 sel8", 12'hB04, 64'd3, 1'b1);
      wr(12'h323, 64'd0);
      hpm_event = 8'hFF;
      repeat (3) tick();
      hpm_event = 8'h00;
      rd("hpm3 sel0", 12'hB03, 64'd1001, 1'b1);
      rd("hpm4 sel8 again", 12'hB04, 64'd6, 1'b1);
      wr(12'h320, 64'h10);
      hpm_event = 8'hFF;
      repeat (2) tick();
      hpm_event = 8'h00;
      rd("hpm4 inhibited", 12'hB04, 64'd6, 1'b1);
      wr(12'h320, 64'h0);

      // shadow and unmapped writes are ignored
      wr(12'hB00, 64'd500);
      wr(12'hC00, 64'd7);
      rd("mcycle after shadow write", 12'hB00, 64'd501, 1'b1);
      wr(12'hB03 + 12'(HPM_NUM), 64'd9);
      wr(12'hC03, 64'd9);
      rd("hpm3 after ignored writes", 12'hB03, 64'd1001, 1'b1);
      rd("hpm4 after ignored writes", 12'hB04, 64'd6, 1'b1);
      rd("mcycle after ignored writes", 12'hB00, 64'd503, 1'b1);

      // mcycle overflow
      wr(12'hB00, all_ones - 64'd1);
      chk_ovf("ovf before wrap", 1'b0);
      tick();
      rd("mcycle max", 12'hB00, all_ones, 1'b1);
      chk_ovf("ovf at max", 1'b0);
      tick();
      rd("mcycle wrapped", 12'hB00, 64'd0, 1'b1);
      chk_ovf("ovf after wrap", OVF_EN);
      tick();
      chk_ovf("ovf sticky", OVF_EN);
      wr(12'hB00, 64'd0);
      chk_ovf("ovf cleared by write", 1'b0);
      rd("mcycle written 0", 12'hB00, 64'd0, 1'b1);
      tick();
      rd("mcycle counts from 0", 12'hB00, 64'd1, 1'b1);
      chk_ovf("ovf stays clear", 1'b0);

      // reset beats a simultaneous write
      csr_addr = 12'hB00; csr_data_write = 64'd77; csr_wen = 1'b1; RST = 1'b1;
      tick();
      RST = 1'b0; csr_wen = 1'b0;
      rd("reset over write", 12'hB00, 64'd0, 1'b1);
      rd("hpm3 reset", 12'hB03, 64'd0, 1'b1);
      rd("hpm4 event reset", 12'h324, 64'd0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
